dtc_output_capture: RTL



---
 rtl/dtc_output_capture_if.sv | 11 +
 rtl/dtc_output_capture.sv | 81 ++++++++
 2 files changed

// File: rtl/dtc_output_capture_if.sv
// dtc_output_capture_if: link, control and host read-port bundle for the output capture buffer
interface dtc_output_capture_if #(parameter int ADDR_W = 9);
  logic BC0, arm, data_valid, capturing, done, overflow, rd_en;
  logic [35:0] data_in, rd_dout;
  logic [ADDR_W:0] word_count;
  logic [ADDR_W-1:0] rd_addr;
  modport master(output BC0, arm, data_in, data_valid, rd_en, rd_addr,
                 input capturing, done, overflow, word_count, rd_dout);
  modport slave(input BC0, arm, data_in, data_valid, rd_en, rd_addr,
                output capturing, done, overflow, word_count, rd_dout);
endinterface

// File: rtl/dtc_output_capture.sv
// dtc_output_capture: BC0-triggered capture window writing valid 36-bit words into a RAM with registered host read-back.
// Build option ZERO_SUPPRESS_EN: valid all-zero words are neither stored nor counted.
module dtc_output_capture #(
  parameter int ADDR_W = 9,
  parameter int WINDOW = 1800
) (
  input  logic clk,
  input  logic reset,
  dtc_output_capture_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] win_q, win_d;
  logic [ADDR_W:0] wc_q, wc_d;
  logic ovf_q, ovf_d;
  logic [35:0] rd_dout_q;
  logic [35:0] mem [DEPTH];
  logic keep, full, we;
`ifdef ZERO_SUPPRESS_EN
  assign keep = bus.data_valid && (bus.data_in != '0);
`else
  assign keep = bus.data_valid;
`endif
  // The count can only reach DEPTH, so its MSB alone marks a full RAM.
  assign full = wc_q[ADDR_W];
  assign we = !reset && state_q == CAPTURE && keep && !full;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      win_q <= '0;
      wc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      wc_q <= wc_d;
      ovf_q <= ovf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    wc_d = wc_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: state_d = bus.arm ? ARMED : IDLE;
      ARMED: begin
        state_d = bus.BC0 ? CAPTURE : ARMED;
        win_d = '0;
      end
      CAPTURE: begin
        win_d = win_q + 16'd1;
        state_d = (win_q == 16'(WINDOW - 1)) ? DONE : CAPTURE;
        wc_d = we ? wc_q + 1'b1 : wc_q;
        ovf_d = ovf_q || (keep && full);
      end
      DONE: begin
        state_d = bus.arm ? ARMED : DONE;
        wc_d = bus.arm ? '0 : wc_q;
        ovf_d = bus.arm ? 1'b0 : ovf_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.capturing = state_q == CAPTURE;
    bus.done = state_q == DONE;
    bus.overflow = ovf_q;
    bus.word_count = wc_q;
    bus.rd_dout = rd_dout_q;
  end
  always_ff @(posedge clk) begin
    if (we) mem[wc_q[ADDR_W-1:0]] <= bus.data_in;
  end
  // Read-before-write: a same-address write in this cycle is not yet visible.
  always_ff @(posedge clk) begin
    if (reset) rd_dout_q <= '0;
    else if (bus.rd_en) rd_dout_q <= mem[bus.rd_addr];
  end
endmodule
